// File: rtl/aes_pkg.sv
// Shared AES constants and the inverse-cipher controller state type.
package aes_pkg;

    localparam int unsigned AES_WORD_SIZE  = 8;
    localparam int unsigned AES_ARRAY_SIZE = 16;
    localparam int unsigned AES_BLOCK_W    = 128;
    localparam int unsigned AES128_NR      = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } inv_ctrl_state_t;

endpackage

// File: rtl/inv_cipher_round_ctrl_if.sv
// Block I/O, round-key store and inverse-round datapath signals of the controller.
// master: the controller; slave: the surrounding logic (source, sink, key store, datapath).
interface inv_cipher_round_ctrl_if
    import aes_pkg::*;
#(
    parameter int unsigned BLOCK_W   = AES_BLOCK_W,
    parameter int unsigned KEY_IDX_W = 4
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [BLOCK_W-1:0]   in_data;
    logic [KEY_IDX_W-1:0] key_idx;
    logic [BLOCK_W-1:0]   key_word;
    logic [BLOCK_W-1:0]   rnd_state;
    logic [BLOCK_W-1:0]   rnd_key;
    logic                 rnd_last;
    logic [BLOCK_W-1:0]   rnd_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLOCK_W-1:0]   out_data;
    logic                 busy;

    modport master (
        input  in_valid, in_data, key_word, rnd_result, out_ready,
        output in_ready, key_idx, rnd_state, rnd_key, rnd_last, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, key_word, rnd_result, out_ready,
        input  in_ready, key_idx, rnd_state, rnd_key, rnd_last, out_valid, out_data, busy
    );

endinterface

// File: rtl/inv_round_cnt.sv
// Loadable down-counter for the inverse-round index, with ==1 and ==0 flags.
module inv_round_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_one_o  = (cnt_q == Width'(1));
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/inv_cipher_round_ctrl.sv
// AES-128 inverse-cipher sequencer: one inverse round per cycle through an external datapath.
// Optional feature macro: INV_CIPHER_ABORT_EN adds an 'abort' input that drops the block in flight.
module inv_cipher_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned word_size  = AES_WORD_SIZE,
    parameter int unsigned array_size = AES_ARRAY_SIZE,
    parameter int unsigned NR         = AES128_NR,
    parameter int unsigned KEY_IDX_W  = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef INV_CIPHER_ABORT_EN
    input  logic abort,
`endif
    inv_cipher_round_ctrl_if.master bus
);

    localparam int unsigned BlockW = word_size * array_size;

    inv_ctrl_state_t     st_q, st_d;
    logic [BlockW-1:0]   state_q, state_d;
    logic                cnt_load, cnt_dec;
    logic [KEY_IDX_W-1:0] cnt;
    logic                cnt_one, cnt_zero;

    inv_round_cnt #(
        .Width (KEY_IDX_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (KEY_IDX_W'(NR - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .is_one_o   (cnt_one),
        .is_zero_o  (cnt_zero)
    );

    // Next-state, state-register update and handshake/round outputs.
    always_comb begin
        st_d          = st_q;
        state_d       = state_q;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.key_idx   = KEY_IDX_W'(NR);
        bus.rnd_last  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (st_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Initial AddRoundKey with the last round key.
                    state_d  = bus.in_data ^ bus.key_word;
                    cnt_load = 1'b1;
                    st_d     = (NR == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                bus.key_idx = cnt;
                state_d     = bus.rnd_result;
                cnt_dec     = !cnt_zero;
                if (cnt_one) begin
                    st_d = FINAL;
                end
            end
            FINAL: begin
                // Counter has reached zero here, so it doubles as key index 0.
                bus.key_idx  = cnt;
                bus.rnd_last = 1'b1;
                state_d      = bus.rnd_result;
                st_d         = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
`ifdef INV_CIPHER_ABORT_EN
        // Abort wins over out_ready; the state register is left as is.
        if (abort && (st_q != IDLE)) begin
            st_d     = IDLE;
            state_d  = state_q;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
`endif
    end

    // FSM and state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
        end
    end

    assign bus.rnd_state = state_q;
    assign bus.rnd_key   = bus.key_word;
    assign bus.out_data  = state_q;
    assign bus.busy      = (st_q != IDLE);

endmodule
